pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/cdc_sync2.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_sync2.sv
// rtl/cdc_sync2.sv - two-flop single-bit synchronizer with asynchronous clear
module cdc_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset / lock-wait / run sequencer driving core reset
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_locked,
    output logic       o_pll_rst,
    output logic       o_rst,
    output logic       o_ready,
    output logic [7:0] o_retries
);

    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PW-1:0] PLL_LAST = PW'(PLL_RST_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT);

    localparam logic [1:0] ST_PLL_RST   = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    logic          locked_s;
    logic [1:0]    state_q,   state_d;
    logic [PW-1:0] pll_cnt_q, pll_cnt_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic [7:0]    retries_q, retries_d;
    logic          pll_rst_q, pll_rst_d;
    logic          rst_q,     rst_d;
    logic          ready_q,   ready_d;

    logic [SW-1:0] stab_next;
    logic [TW-1:0] to_next;
    logic [7:0]    retries_inc;

    cdc_sync2 u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_locked),
        .o_q   (locked_s)
    );

    always_comb begin
        state_d     = state_q;
        pll_cnt_d   = pll_cnt_q;
        stab_cnt_d  = stab_cnt_q;
        to_cnt_d    = to_cnt_q;
        retries_d   = retries_q;
        pll_rst_d   = pll_rst_q;
        rst_d       = rst_q;
        ready_d     = ready_q;
        stab_next   = locked_s ? stab_cnt_q + SW'(1) : '0;
        to_next     = to_cnt_q + TW'(1);
        retries_inc = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;

        case (state_q)
            ST_PLL_RST: begin
                if (pll_cnt_q == PLL_LAST) begin
                    state_d    = ST_WAIT_LOCK;
                    pll_cnt_d  = '0;
                    stab_cnt_d = '0;
                    to_cnt_d   = '0;
                    pll_rst_d  = 1'b0;
                end else begin
                    pll_cnt_d = pll_cnt_q + PW'(1);
                end
            end
            ST_WAIT_LOCK: begin
                stab_cnt_d = stab_next;
                to_cnt_d   = to_next;
                // Stability wins over a simultaneous timeout.
                if (stab_next == STAB_MAX) begin
                    state_d = ST_RUN;
                    rst_d   = 1'b0;
                    ready_d = 1'b1;
                end else if (to_next == TO_MAX) begin
                    state_d   = ST_PLL_RST;
                    pll_cnt_d = '0;
                    pll_rst_d = 1'b1;
                    retries_d = retries_inc;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d   = ST_PLL_RST;
                    pll_cnt_d = '0;
                    pll_rst_d = 1'b1;
                    rst_d     = 1'b1;
                    ready_d   = 1'b0;
                    retries_d = retries_inc;
                end
            end
            default: begin
                state_d   = ST_PLL_RST;
                pll_cnt_d = '0;
                pll_rst_d = 1'b1;
                rst_d     = 1'b1;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_PLL_RST;
            pll_cnt_q  <= '0;
            stab_cnt_q <= '0;
            to_cnt_q   <= '0;
            retries_q  <= '0;
            pll_rst_q  <= 1'b1;
            rst_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pll_cnt_q  <= pll_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            to_cnt_q   <= to_cnt_d;
            retries_q  <= retries_d;
            pll_rst_q  <= pll_rst_d;
            rst_q      <= rst_d;
            ready_q    <= ready_d;
        end
    end

    assign o_pll_rst = pll_rst_q;
    assign o_rst     = rst_q;
    assign o_ready   = ready_q;
    assign o_retries = retries_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int P_PLL  = 4;
    localparam int P_STAB = 8;
    localparam int P_TO   = 20;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_locked = 1'b0;
    logic       o_pll_rst;
    logic       o_rst;
    logic       o_ready;
    logic [7:0] o_retries;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P_PLL),
        .STABLE_CYCLES  (P_STAB),
        .LOCK_TIMEOUT   (P_TO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_locked  (i_locked),
        .o_pll_rst (o_pll_rst),
        .o_rst     (o_rst),
        .o_ready   (o_ready),
        .o_retries (o_retries)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [10:0] v; } ev_t;
    typedef struct { string name; int act; int req; } dc_t;

    ev_t exp_q[$];
    dc_t dq[$];
    int  cyc = 0;
    int  nchk = 0;
    int  nfail = 0;
    bit  done = 0;

    // Reference model: mode 0 = holding PLL in reset, 1 = waiting for lock, 2 = running.
    int         m_mode = 0;
    int         m_n = 0;
    int         m_streak = 0;
    int         m_retries = 0;
    logic       lk_hist[$] = '{1'b0, 1'b0};
    logic [10:0] exp_last = {1'b1, 1'b1, 1'b0, 8'd0};

    initial forever begin
        logic       seen;
        logic [10:0] nv;
        @(posedge clk or posedge i_rst);
        if (i_rst) begin
            m_mode = 0; m_n = 0; m_streak = 0; m_retries = 0;
            lk_hist = '{1'b0, 1'b0};
        end else begin
            cyc++;
            seen = lk_hist.pop_front();
            lk_hist.push_back(i_locked);
            if (m_mode == 0) begin
                m_n++;
                if (m_n == P_PLL) begin m_mode = 1; m_n = 0; m_streak = 0; end
            end else if (m_mode == 1) begin
                m_n++;
                m_streak = seen ? m_streak + 1 : 0;
                if (m_streak == P_STAB) m_mode = 2;
                else if (m_n == P_TO) begin
                    m_mode = 0; m_n = 0;
                    m_retries = (m_retries < 255) ? m_retries + 1 : 255;
                end
            end else if (!seen) begin
                m_mode = 0; m_n = 0;
                m_retries = (m_retries < 255) ? m_retries + 1 : 255;
            end
        end
        nv = {m_mode == 0, m_mode != 2, m_mode == 2, 8'(m_retries)};
        if (nv != exp_last) begin
            exp_q.push_back('{cyc: cyc, v: nv});
            exp_last = nv;
        end
    end

    initial forever begin
        logic [10:0] cur;
        logic [10:0] last_v;
        ev_t e;
        dc_t d;
        last_v = {1'b1, 1'b1, 1'b0, 8'd0};
        forever begin
            @(negedge clk);
            cur = {o_pll_rst, o_rst, o_ready, o_retries};
            if (cur !== last_v) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL out_event: got pll_rst/rst/ready/retries=%b/%b/%b/%0d at edge %0d, required no change",
                             cur[10], cur[9], cur[8], cur[7:0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.v !== cur || e.cyc != cyc) begin
                        nfail++;
                        $display("FAIL out_event: got %b/%b/%b/%0d at edge %0d, required %b/%b/%b/%0d at edge %0d",
                                 cur[10], cur[9], cur[8], cur[7:0], cyc,
                                 e.v[10], e.v[9], e.v[8], e.v[7:0], e.cyc);
                    end
                end
                last_v = cur;
            end
            if (o_rst === 1'b0) begin
                nchk++;
                if (o_pll_rst !== 1'b0 || o_ready !== 1'b1) begin
                    nfail++;
                    $display("FAIL rst_invariant: o_rst=0 with pll_rst=%b ready=%b, required 0/1", o_pll_rst, o_ready);
                end
            end
            while (dq.size() > 0) begin
                d = dq.pop_front();
                nchk++;
                if (d.act != d.req) begin
                    nfail++;
                    $display("FAIL %s: got %0d, required %0d", d.name, d.act, d.req);
                end
            end
            if (done) begin
                if (exp_q.size() != 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL pending_events: got %0d unmatched expected events, required 0", exp_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
                $finish;
            end
        end
    end

    task automatic push_direct(input string name, input int act, input int req);
        dq.push_back('{name: name, act: act, req: req});
    endtask

    task automatic wait_out(input int sel, input logic val, input int budget, input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (((sel == 0) ? o_pll_rst : o_ready) === val) begin
                ok = 1;
                break;
            end
        end
        if (!ok) push_direct({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int c0;
        int cf;
        repeat (3) @(negedge clk);
        push_direct("reset_pll_rst", int'(o_pll_rst), 1);
        push_direct("reset_rst", int'(o_rst), 1);
        push_direct("reset_ready", int'(o_ready), 0);
        push_direct("reset_retries", int'(o_retries), 0);

        // Clean bring-up: lock asserts once the PLL leaves reset.
        @(negedge clk);
        i_rst = 1'b0;
        c0 = cyc;
        wait_out(0, 1'b0, 50, "bringup_pll_fall");
        cf = cyc;
        push_direct("pll_rst_len", cf - c0, P_PLL);
        @(negedge clk);
        i_locked = 1'b1;
        wait_out(1, 1'b1, 60, "bringup_ready");
        push_direct("lock_to_ready", cyc - cf, 2 + P_STAB);
        push_direct("bringup_retries", int'(o_retries), 0);

        // One-cycle lock loss in RUN.
        @(negedge clk);
        i_locked = 1'b0;
        c0 = cyc;
        @(negedge clk);
        i_locked = 1'b1;
        for (int k = 0; k < 10 && cyc < c0 + 3; k++) begin
            @(posedge clk);
            #1;
        end
        push_direct("loss_rst", int'(o_rst), 1);
        push_direct("loss_ready", int'(o_ready), 0);
        push_direct("loss_pll_rst", int'(o_pll_rst), 1);
        push_direct("loss_retries", int'(o_retries), 1);
        wait_out(1, 1'b1, 60, "relock_ready");

        // Glitch during lock wait restarts stability counting.
        @(negedge clk);
        i_locked = 1'b0;
        wait_out(0, 1'b1, 20, "glitch_pll_rise");
        wait_out(0, 1'b0, 20, "glitch_pll_fall");
        cf = cyc;
        @(negedge clk);
        i_locked = 1'b1;
        repeat (6) @(negedge clk);
        i_locked = 1'b0;
        @(negedge clk);
        i_locked = 1'b1;
        wait_out(1, 1'b1, 60, "glitch_ready");
        push_direct("glitch_release", cyc - cf, 17);

        for (int r = 0; r < 60; r++) begin
            i_locked = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        // Asynchronous reset while running.
        i_locked = 1'b1;
        wait_out(1, 1'b1, 200, "pre_async_ready");
        @(posedge clk);
        #2;
        i_rst = 1'b1;
        #1;
        push_direct("async_rst", int'(o_rst), 1);
        push_direct("async_pll_rst", int'(o_pll_rst), 1);
        push_direct("async_ready", int'(o_ready), 0);
        push_direct("async_retries", int'(o_retries), 0);
        @(negedge clk);
        i_locked = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;

        repeat (300 * (P_PLL + P_TO) + 20) @(negedge clk);
        push_direct("retries_saturate", int'(o_retries), 255);
        repeat (2) @(negedge clk);
        done = 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
